// File: rtl/sc_lane_scheduler.sv
// rtl/sc_lane_scheduler.sv - stochastic multiply lane scheduler (optional SC_BIPOLAR_EN: bipolar results)
module sc_lane_scheduler #(
    parameter int LANES      = 4,
    parameter int STREAM_LEN = 16,
    parameter int SNG_LAT    = 2,
    parameter int CNT_W      = $clog2(STREAM_LEN + 1),
    parameter int RES_W      = CNT_W + 1
) (
    input  logic                   i_clk_sch,
    input  logic                   i_rst_sch,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [4*LANES-1:0]     i_x_bn,
    input  logic [4*LANES-1:0]     i_w_bn,
    output logic [4*LANES-1:0]     o_x_bn,
    output logic [4*LANES-1:0]     o_w_bn,
    output logic                   o_start_sng,
    output logic                   o_stop_sng,
    input  logic [LANES-1:0]       i_sn_prod,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [RES_W*LANES-1:0] o_result,
    output logic                   o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GEN,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [7:0]       WAIT_INIT = 8'(SNG_LAT - 1);
    localparam logic [CNT_W-1:0] LEN_CNT   = CNT_W'(STREAM_LEN);
    localparam logic [CNT_W-1:0] LEN_M1    = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t                   state;
    state_t                   state_nxt;
    logic [7:0]               wait_cnt;
    logic [CNT_W-1:0]         cyc_cnt;
    logic [CNT_W-1:0]         lane_cnt [LANES];
    logic [RES_W*LANES-1:0]   res_conv;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_in_valid) state_nxt = S_START;
            // With SNG_LAT of 1 there is no latency to hide, so WAIT is skipped.
            S_START: state_nxt = (WAIT_INIT == 8'd0) ? S_GEN : S_WAIT;
            S_WAIT:  if (wait_cnt <= 8'd1) state_nxt = S_GEN;
            S_GEN:   if (cyc_cnt == LEN_M1) state_nxt = S_STOP;
            S_STOP:  state_nxt = S_DONE;
            S_DONE:  if (i_out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        res_conv = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef SC_BIPOLAR_EN
            res_conv[k*RES_W +: RES_W] = {lane_cnt[k], 1'b0} - RES_W'(STREAM_LEN);
`else
            res_conv[k*RES_W +: RES_W] = {1'b0, lane_cnt[k]};
`endif
        end
    end

    always_ff @(posedge i_clk_sch) begin
        if (i_rst_sch) begin
            state    <= S_IDLE;
            o_x_bn   <= '0;
            o_w_bn   <= '0;
            o_result <= '0;
            wait_cnt <= '0;
            cyc_cnt  <= '0;
            for (int k = 0; k < LANES; k++) lane_cnt[k] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        o_x_bn <= i_x_bn;
                        o_w_bn <= i_w_bn;
                        for (int k = 0; k < LANES; k++) lane_cnt[k] <= '0;
                    end
                end
                S_START: begin
                    wait_cnt <= WAIT_INIT;
                    cyc_cnt  <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 8'd1;
                    cyc_cnt  <= '0;
                end
                S_GEN: begin
                    for (int k = 0; k < LANES; k++) begin
                        if (i_sn_prod[k] && (lane_cnt[k] < LEN_CNT))
                            lane_cnt[k] <= lane_cnt[k] + CNT_ONE;
                    end
                    if (cyc_cnt < LEN_CNT) cyc_cnt <= cyc_cnt + CNT_ONE;
                end
                S_STOP: o_result <= res_conv;
                default: ;
            endcase
        end
    end

    assign o_in_ready  = (state == S_IDLE);
    assign o_start_sng = (state == S_START);
    assign o_stop_sng  = (state == S_STOP);
    assign o_out_valid = (state == S_DONE);
    assign o_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_sc_lane_scheduler.sv
// tb/tb_sc_lane_scheduler.sv - directed table-driven bench for sc_lane_scheduler
module tb_sc_lane_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in, w_in, x_bn, w_bn;
    logic        start_sng, stop_sng;
    logic [3:0]  sn_prod;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] result;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sc_lane_scheduler dut (
        .i_clk_sch   (clk),
        .i_rst_sch   (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_x_bn      (x_in),
        .i_w_bn      (w_in),
        .o_x_bn      (x_bn),
        .o_w_bn      (w_bn),
        .o_start_sng (start_sng),
        .o_stop_sng  (stop_sng),
        .i_sn_prod   (sn_prod),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_result    (result),
        .o_busy      (busy)
    );

    // pat: lane k at [16k+15:16k], bit i = product bit on GEN sample i.
    // side: product bits driven in START/WAIT/STOP, which must not count.
    typedef struct {
        logic [15:0] x;
        logic [15:0] w;
        logic [63:0] pat;
        logic [3:0]  side;
        logic [19:0] cnt;
        int          hold;
    } vec_t;

    vec_t tab [4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] exp_res(input int c);
`ifdef SC_BIPOLAR_EN
        return 6'(2 * c - 16);
`else
        return 6'(c);
`endif
    endfunction

    function automatic logic [23:0] exp_vec(input logic [19:0] cnt);
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[6*k +: 6] = exp_res(int'(cnt[5*k +: 5]));
        return r;
    endfunction

    task automatic run_job(input vec_t v);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick;
            guard++;
        end
        chk("ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        x_in      = v.x;
        w_in      = v.w;
        out_ready = 1'b1;
        sn_prod   = v.side;
        tick;
        in_valid = 1'b0;
        x_in     = ~v.x;
        w_in     = ~v.w;
        for (int c = 1; c <= 19; c++) begin
            if (c >= 3 && c <= 18) begin
                for (int k = 0; k < 4; k++) sn_prod[k] = v.pat[16*k + c - 3];
            end else begin
                sn_prod = v.side;
            end
            chk("start_pulse", start_sng, (c == 1));
            chk("stop_pulse", stop_sng, (c == 19));
            chk("valid_early", out_valid, 0);
            chk("busy_in_job", busy, 1);
            chk("x_bn_held", x_bn, v.x);
            chk("w_bn_held", w_bn, v.w);
            tick;
        end
        sn_prod = '0;
        chk("valid_at_19", out_valid, 1);
        chk("result", result, exp_vec(v.cnt));
        for (int h = 0; h < v.hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            tick;
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_result", result, exp_vec(v.cnt));
            chk("bp_x_bn", x_bn, v.x);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
        chk("release_busy", busy, 0);
    endtask

    initial begin
        logic [62:0] smask, tmask, es, et;
        int guard;

        tab[0] = '{x: 16'h1234, w: 16'hFFFF, pat: {16'h0000, 16'h0000, 16'h5555, 16'hFFFF},
                   side: 4'b1000, cnt: {5'd0, 5'd0, 5'd8, 5'd16}, hold: 0};
        tab[1] = '{x: 16'hCAFE, w: 16'h0F1E, pat: {16'h0FFF, 16'h0000, 16'h00FF, 16'hFFFF},
                   side: 4'b1111, cnt: {5'd12, 5'd0, 5'd8, 5'd16}, hold: 10};
        tab[2] = '{x: 16'hA5A5, w: 16'h5A5A, pat: {16'h1248, 16'h7FFF, 16'h8000, 16'h0001},
                   side: 4'b0000, cnt: {5'd4, 5'd15, 5'd1, 5'd1}, hold: 3};
        tab[3] = '{x: 16'h0001, w: 16'h8000, pat: {16'h3C3C, 16'hAAAA, 16'hFFFF, 16'h0000},
                   side: 4'b0101, cnt: {5'd8, 5'd8, 5'd16, 5'd0}, hold: 0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x_in = '0;
        w_in = '0;
        sn_prod = '0;
        tick;
        tick;
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_start", start_sng, 0);
        chk("rst_stop", stop_sng, 0);
        chk("rst_x_bn", x_bn, 0);
        chk("rst_w_bn", w_bn, 0);
        chk("rst_result", result, 0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 4; i++) run_job(tab[i]);

        // Three back-to-back jobs: pulses every 21 cycles, stop 18 after start.
        in_valid  = 1'b1;
        x_in      = 16'hBEEF;
        w_in      = 16'h0F0F;
        out_ready = 1'b1;
        guard = 0;
        while (!start_sng && guard < 30) begin
            tick;
            guard++;
        end
        chk("pulse_first_start", start_sng, 1);
        smask = '0;
        tmask = '0;
        for (int i = 0; i < 63; i++) begin
            smask[i] = start_sng;
            tmask[i] = stop_sng;
            tick;
        end
        in_valid = 1'b0;
        es = '0;
        et = '0;
        es[0] = 1'b1; es[21] = 1'b1; es[42] = 1'b1;
        et[18] = 1'b1; et[39] = 1'b1; et[60] = 1'b1;
        chk("start_pulse_train", smask, es);
        chk("stop_pulse_train", tmask, et);
        guard = 0;
        while (busy && guard < 60) begin
            tick;
            guard++;
        end
        chk("drain_idle", busy, 0);

        // Reset during the 5th GEN cycle.
        in_valid = 1'b1;
        x_in = 16'h1111;
        w_in = 16'h2222;
        sn_prod = 4'hF;
        tick;
        in_valid = 1'b0;
        repeat (6) tick;
        chk("mid_gen_busy", busy, 1);
        rst = 1'b1;
        tick;
        chk("mrst_ready", in_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_stop", stop_sng, 0);
        chk("mrst_start", start_sng, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_x_bn", x_bn, 0);
        chk("mrst_w_bn", w_bn, 0);
        chk("mrst_result", result, 0);
        rst = 1'b0;
        sn_prod = '0;
        tick;
        run_job(tab[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sc_lane_scheduler.md
Name: sc_lane_scheduler

Overview:
Sequences a bank of LANES stochastic number generator lanes, each with two SNGs (x, w) feeding an external AND gate, to perform one stochastic multiply per lane per job. It takes binary operand vectors over a valid/ready handshake, holds them on the SNG inputs, and pulses the SNG start and stop controls. It counts the ones in each lane's product bit stream over a STREAM_LEN window and returns the per-lane counts over a valid/ready handshake. It sits between the layer controller and the SNG/AND datapath.

Parameters:
LANES, 4, number of parallel multiply lanes
STREAM_LEN, 16, counted stream length in cycles per job (2..255)
SNG_LAT, 2, cycles from start pulse to first valid product bit; these cycles are not counted
CNT_W, 5, count width per lane, = clog2(STREAM_LEN+1)
RES_W, 6, result width per lane, = CNT_W+1

Ports:
i_clk_sch  in  1  clock
i_rst_sch  in  1  synchronous active-high reset
i_in_valid  in  1  operand vector valid
o_in_ready  out  1  scheduler accepts operands (IDLE only)
i_x_bn  in  4*LANES  x operands, lane k at [4k+3:4k]
i_w_bn  in  4*LANES  w operands, same packing
o_x_bn  out  4*LANES  latched x to SNGs
o_w_bn  out  4*LANES  latched w to SNGs
o_start_sng  out  1  one-cycle start pulse to all SNGs
o_stop_sng  out  1  one-cycle stop pulse to all SNGs
i_sn_prod  in  LANES  product bit per lane (x AND w stream)
o_out_valid  out  1  results valid
i_out_ready  in  1  downstream accepts results
o_result  out  RES_W*LANES  per-lane result, lane k at [RES_W*k+RES_W-1:RES_W*k]
o_busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, i_rst_sch high at a clock edge): state=IDLE; o_x_bn, o_w_bn, o_result, counters=0; o_start_sng=o_stop_sng=o_out_valid=0; o_in_ready=1. Reset overrides every other input in that cycle, including mid-job; the SNGs are not sent a stop pulse.
- States: IDLE, START, WAIT, GEN, STOP, DONE.
- IDLE: o_in_ready=1. On i_in_valid&&o_in_ready, latch i_x_bn/i_w_bn into o_x_bn/o_w_bn, clear lane counters, and go to START.
- START: o_start_sng=1 for exactly this cycle. Load wait counter=SNG_LAT-1, then go to WAIT.
- WAIT: hold SNG_LAT-1 cycles, decrementing. When the count reaches 0, load cycle counter=0 and go to GEN. The first counted sample is therefore SNG_LAT cycles after the o_start_sng cycle.
- GEN: each cycle, lane counter k += i_sn_prod[k], and the cycle counter increments. After exactly STREAM_LEN samples (cycle counter == STREAM_LEN-1 sampled), go to STOP. Counters saturate at STREAM_LEN and never wrap.
- STOP: o_stop_sng=1 for exactly this cycle; i_sn_prod is ignored. Copy the counts into o_result and go to DONE.
- DONE: o_out_valid=1; o_result and o_x_bn/o_w_bn are held stable. On i_out_ready, go to IDLE and deassert o_out_valid in the next cycle. With i_out_ready held high, DONE lasts 1 cycle.
- Latency, accept to o_out_valid: 1(START) + SNG_LAT-1(WAIT) + STREAM_LEN(GEN) + 1(STOP) = 19 cycles at defaults. Minimum job period = latency + 1(DONE) + 1(IDLE) = 21 cycles.
- i_in_valid outside IDLE is ignored; o_in_ready=0 there. Operands change only on acceptance.
- o_start_sng and o_stop_sng are never high in the same cycle, and never high outside START/STOP.
- Unipolar result = zero-extended count, range 0..STREAM_LEN.

Optional Feature:
Macro SC_BIPOLAR_EN.
- Defined: o_result[k] = 2*count[k] - STREAM_LEN as a signed RES_W two's-complement value. Range is -STREAM_LEN..+STREAM_LEN; at defaults, count 16 -> +16 (6'b010000) and count 0 -> -16 (6'b110000).
- Undefined: unipolar result as above. Timing and handshake are identical in both builds.

Test Plan:
- Reset, then accept x=16'h1234, w=16'hFFFF. o_start_sng rises the cycle after acceptance; o_x_bn=16'h1234 and o_w_bn=16'hFFFF while busy; o_out_valid at acceptance+19.
- Drive i_sn_prod = lane0 always 1, lane1 alternating starting with 1, lane2 always 0, lane3 =1 only in the WAIT and STOP cycles. Required o_result = 16, 8, 0, 0.
- Back-pressure: hold i_out_ready=0 for 10 cycles in DONE. o_result is stable, o_in_ready=0, and a new i_in_valid is ignored. Release -> IDLE next cycle; the next job is accepted.
- Pulse check: across 3 back-to-back jobs with i_in_valid and i_out_ready held high, exactly 3 start and 3 stop pulses, each 1 cycle wide, spaced 21 cycles apart.
- Reset asserted at the 5th GEN cycle: next cycle state IDLE, all outputs 0, o_in_ready=1, no o_stop_sng. A following job counts from 0 (all-ones lane gives 16).
- SC_BIPOLAR_EN build: lane counts 16, 8, 0, 12 -> o_result = +16, 0, -16, +8.
